// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width.
package arith_pkg;
  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// Start/operand request and busy/done/result response bundle for the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = arith_pkg::ARITH_W);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, borrow-out in bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock LSB first through one cell.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic clk,
  input  logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0]    cnt;
  logic             borrow, busy_q, done_q;
  logic             load, step, d, bo;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
             end
      SHIFT: begin
               step = 1'b1;
               if (cnt == LAST) state_nxt = DONE;
             end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH shifts the LSB lands at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      res    <= '0;
      borrow <= bus.bin;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res    <= {d, res[WIDTH-1:1]};
      borrow <= bo;
      cnt    <= cnt + CW'(1);
    end
  end

  // Flags come from next-state so they are clean flops rather than state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = res;
  assign bus.bout = borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed table, random ops, exhaustive 4-bit sweep, cell truth table.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic fx, fy, fz, fd, fb;
  full_subtractor u_fs (.x(fx), .y(fy), .bin(fz), .d(fd), .bout(fb));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic logic [8:0] model(input int w, input int ma, input int mb, input int mbin);
    int t;
    int m;
    t = ma - mb - mbin;
    m = (1 << w) - 1;
    return {(ma < mb + mbin) ? 1'b1 : 1'b0, 8'(t & m)};
  endfunction

  // One 8-bit op; optional mid-op re-pulse of start (poke_at) or reset (rst_at).
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                     input int poke_at, input int rst_at,
                     output logic [7:0] rd, output logic rb,
                     output int lat, output int busy_n, output int done_n);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = ta; bus8.b = tb_v; bus8.bin = tbin;
    @(posedge clk);
    lat = -1; busy_n = 0; done_n = 0; rd = '0; rb = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus8.busy === 1'b1) busy_n++;
      if (bus8.done === 1'b1) begin
        done_n++;
        if (lat < 0) begin lat = i; rd = bus8.diff; rb = bus8.bout; end
      end
      if (i == 0) begin
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      end
      if (i == poke_at) begin
        bus8.start = 1'b1; bus8.a = 8'd5; bus8.b = 8'd77; bus8.bin = 1'b1;
      end
      if (i == poke_at + 1) bus8.start = 1'b0;
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", 32'(bus8.busy), 0);
        chk("rst_async_done", 32'(bus8.done), 0);
        chk("rst_async_diff", 32'(bus8.diff), 0);
        chk("rst_async_bout", 32'(bus8.bout), 0);
      end
      if (i == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  task automatic run_check(input string nm, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tbin, input logic [7:0] ed, input logic eb, input bit timing);
    logic [7:0] rd;
    logic       rb;
    int lat, bn, dn;
    op8(ta, tb_v, tbin, -1, -1, rd, rb, lat, bn, dn);
    chk({nm, "_diff"}, 32'(rd), 32'(ed));
    chk({nm, "_bout"}, 32'(rb), 32'(eb));
    chk({nm, "_ndone"}, 32'(dn), 1);
    chk({nm, "_hold"}, 32'(bus8.diff), 32'(ed));
    if (timing) begin
      chk({nm, "_lat"}, 32'(lat), 8);
      chk({nm, "_busy"}, 32'(bn), 9);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] m;
    logic [7:0] rd;
    logic       rb;
    int lat, bn, dn, cyc, prev;
    bit got;

    vt[0] = '{a: 8'd200, b: 8'd55,  bin: 1'b0, d: 8'd145, bo: 1'b0};
    vt[1] = '{a: 8'd55,  b: 8'd200, bin: 1'b0, d: 8'd111, bo: 1'b1};
    vt[2] = '{a: 8'd0,   b: 8'd0,   bin: 1'b1, d: 8'd255, bo: 1'b1};
    vt[3] = '{a: 8'hFF,  b: 8'hFF,  bin: 1'b0, d: 8'd0,   bo: 1'b0};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus8.busy), 0);
    chk("reset_done", 32'(bus8.done), 0);
    chk("reset_diff", 32'(bus8.diff), 0);
    chk("reset_bout", 32'(bus8.bout), 0);
    chk("reset4_busy", 32'(bus4.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cell truth table
    for (int r = 0; r < 8; r++) begin
      fx = r[2]; fy = r[1]; fz = r[0];
      #1;
      m = model(1, int'(fx), int'(fy), int'(fz));
      chk($sformatf("fs_d_%0d", r), 32'(fd), 32'(m[0]));
      chk($sformatf("fs_b_%0d", r), 32'(fb), 32'(m[8]));
    end

    for (int k = 0; k < 4; k++)
      run_check($sformatf("vec%0d", k), vt[k].a, vt[k].b, vt[k].bin, vt[k].d, vt[k].bo, 1'b1);

    for (int k = 0; k < 30; k++) begin
      logic [7:0] ra, rbv;
      logic       rbin;
      ra = 8'($urandom); rbv = 8'($urandom); rbin = 1'($urandom);
      m = model(8, int'(ra), int'(rbv), int'(rbin));
      run_check($sformatf("rnd%0d", k), ra, rbv, rbin, m[7:0], m[8], k < 3);
    end

    // start re-pulsed three cycles into SHIFT must be ignored
    op8(8'd100, 8'd30, 1'b0, 3, -1, rd, rb, lat, bn, dn);
    chk("poke_diff", 32'(rd), 70);
    chk("poke_bout", 32'(rb), 0);
    chk("poke_ndone", 32'(dn), 1);
    chk("poke_lat", 32'(lat), 8);
    chk("poke_idle_after", 32'(bus8.busy), 0);

    // reset four cycles into SHIFT: no done, then a clean op
    op8(8'd77, 8'd11, 1'b0, -1, 4, rd, rb, lat, bn, dn);
    chk("rst_ndone", 32'(dn), 0);
    chk("rst_idle_after", 32'(bus8.busy), 0);
    run_check("after_rst", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b1);

    // Exhaustive 4-bit sweep with start held high
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd0; bus4.b = 4'd0; bus4.bin = 1'b0;
    cyc = 0; prev = 0;
    for (int k = 0; k < 512; k++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        cyc++;
        if (bus4.done === 1'b1) got = 1'b1;
      end
      if (!got) begin
        chk($sformatf("w4_timeout_%0d", k), 0, 1);
        break;
      end
      m = model(4, (k >> 5) & 15, (k >> 1) & 15, k & 1);
      chk($sformatf("w4_diff_%0d", k), 32'(bus4.diff), 32'(m[3:0]));
      chk($sformatf("w4_bout_%0d", k), 32'(bus4.bout), 32'(m[8]));
      if (k > 0) chk($sformatf("w4_period_%0d", k), 32'(cyc - prev), 6);
      prev = cyc;
      if (k == 511) bus4.start = 1'b0;
      else begin
        bus4.a = 4'(((k + 1) >> 5) & 15);
        bus4.b = 4'(((k + 1) >> 1) & 15);
        bus4.bin = 1'((k + 1) & 1);
      end
    end
    repeat (8) @(negedge clk);
    chk("w4_idle_end", 32'(bus4.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
